// File: rtl/puf_majority_sampler.sv
// rtl/puf_majority_sampler.sv - N-read majority-vote sequencer for a memristive PUF core
module puf_majority_sampler #(
  parameter int N_CHAL        = 8,
  parameter int N_RESP        = 8,
  parameter int NUM_READS     = 5,
  parameter int RESET_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 20,
  localparam int CNT_W        = $clog2(NUM_READS + 1),
  localparam int UC_W         = $clog2(N_RESP + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              chal_valid,
  output logic              chal_ready,
  input  logic [N_CHAL-1:0] chal,
  output logic              core_rst_n,
  output logic              core_vin_valid,
  output logic [N_CHAL-1:0] core_C,
  input  logic [N_RESP-1:0] core_R,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [N_RESP-1:0] resp,
  output logic [N_RESP-1:0] unstable_mask,
  output logic [UC_W-1:0]   unstable_cnt,
  output logic              busy
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CRST   = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] SAMPLE = 3'd3;
  localparam logic [2:0] EVAL   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  localparam int TMR_MAX = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  logic [2:0]       state;
  logic [TMR_W-1:0] tmr;
  logic [CNT_W-1:0] read_idx;
  logic [CNT_W-1:0] ones [N_RESP];

  logic [N_RESP-1:0] vote;
  logic [N_RESP-1:0] mask_next;
  logic [UC_W-1:0]   cnt_next;

  assign chal_ready     = (state == IDLE);
  assign busy           = !chal_ready;
  // The core only sees reset released while it is settling or being sampled.
  assign core_rst_n     = (state == SETTLE) || (state == SAMPLE);
  assign core_vin_valid = (state == SETTLE);

  always_comb begin
    vote      = '0;
    mask_next = '0;
    cnt_next  = '0;
    for (int i = 0; i < N_RESP; i++) begin
      vote[i]      = (2 * int'(ones[i])) > NUM_READS;
      mask_next[i] = (ones[i] != '0) && (int'(ones[i]) != NUM_READS);
      cnt_next     = cnt_next + UC_W'(mask_next[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tmr           <= '0;
      read_idx      <= '0;
      core_C        <= '0;
      resp_valid    <= 1'b0;
      resp          <= '0;
      unstable_mask <= '0;
      unstable_cnt  <= '0;
      for (int i = 0; i < N_RESP; i++) ones[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (chal_valid) begin
            core_C   <= chal;
            read_idx <= '0;
            tmr      <= '0;
            for (int i = 0; i < N_RESP; i++) ones[i] <= '0;
            state    <= CRST;
          end
        end
        CRST: begin
          if (tmr == TMR_W'(RESET_CYCLES - 1)) begin
            tmr   <= '0;
            state <= SETTLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        SETTLE: begin
          if (tmr == TMR_W'(SETTLE_CYCLES - 1)) begin
            tmr   <= '0;
            state <= SAMPLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        SAMPLE: begin
          for (int i = 0; i < N_RESP; i++) ones[i] <= ones[i] + CNT_W'(core_R[i]);
          read_idx <= read_idx + 1'b1;
          state    <= (int'(read_idx) + 1 < NUM_READS) ? CRST : EVAL;
        end
        EVAL: begin
          resp          <= vote;
          unstable_mask <= mask_next;
          unstable_cnt  <= cnt_next;
          resp_valid    <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_majority_sampler.sv
// tb/tb_puf_majority_sampler.sv - self-checking bench for puf_majority_sampler
module tb_puf_majority_sampler;

  localparam int LAT5 = 5 * (2 + 20 + 1) + 1;
  localparam int LAT4 = 4 * (2 + 20 + 1) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic       chal_valid = 1'b0, resp_ready = 1'b0;
  logic [7:0] chal = '0;
  logic       chal_ready, core_rst_n, core_vin_valid, resp_valid, busy;
  logic [7:0] core_C, core_R, resp, unstable_mask;
  logic [3:0] unstable_cnt;

  logic       chal_valid4 = 1'b0, resp_ready4 = 1'b1;
  logic [7:0] chal4 = '0;
  logic       chal_ready4, core_rst_n4, core_vin_valid4, resp_valid4, busy4;
  logic [7:0] core_C4, core_R4, resp4, unstable_mask4;
  logic [3:0] unstable_cnt4;

  puf_majority_sampler dut (
    .clk(clk), .rst_n(rst_n), .chal_valid(chal_valid), .chal_ready(chal_ready), .chal(chal),
    .core_rst_n(core_rst_n), .core_vin_valid(core_vin_valid), .core_C(core_C), .core_R(core_R),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp(resp), .unstable_mask(unstable_mask),
    .unstable_cnt(unstable_cnt), .busy(busy)
  );

  puf_majority_sampler #(.NUM_READS(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .chal_valid(chal_valid4), .chal_ready(chal_ready4), .chal(chal4),
    .core_rst_n(core_rst_n4), .core_vin_valid(core_vin_valid4), .core_C(core_C4), .core_R(core_R4),
    .resp_valid(resp_valid4), .resp_ready(resp_ready4), .resp(resp4), .unstable_mask(unstable_mask4),
    .unstable_cnt(unstable_cnt4), .busy(busy4)
  );

  // Core model: per-read response table, garbage whenever the core is held in reset.
  logic [7:0] pat  [0:7];
  logic [7:0] pat4 [0:7];
  logic [7:0] rd_cnt = '0, rd_cnt4 = '0;
  logic       prev_crn = 1'b0, prev_crn4 = 1'b0;
  logic [7:0] noise = '0;

  always @(negedge clk) noise <= 8'($urandom);
  assign core_R  = core_rst_n  ? pat[rd_cnt[2:0]]   : noise;
  assign core_R4 = core_rst_n4 ? pat4[rd_cnt4[2:0]] : ~noise;

  always @(posedge clk) begin
    prev_crn  <= core_rst_n;
    prev_crn4 <= core_rst_n4;
    if (chal_valid && chal_ready) rd_cnt <= '0;
    else if (prev_crn && !core_rst_n) rd_cnt <= rd_cnt + 8'd1;
    if (chal_valid4 && chal_ready4) rd_cnt4 <= '0;
    else if (prev_crn4 && !core_rst_n4) rd_cnt4 <= rd_cnt4 + 8'd1;
  end

  // Per bit: majority means strictly more ones than zeros; unstable means both values seen.
  function automatic void model(input int sel, input int nr,
                                output logic [7:0] r, output logic [7:0] m, output logic [3:0] c);
    int ones, zeros;
    logic [7:0] p;
    r = '0; m = '0;
    for (int b = 0; b < 8; b++) begin
      ones = 0;
      for (int k = 0; k < nr; k++) begin
        p = (sel == 0) ? pat[k] : pat4[k];
        if (p[b]) ones++;
      end
      zeros = nr - ones;
      r[b] = ones > zeros;
      m[b] = (ones > 0) && (zeros > 0);
    end
    c = 4'($countones(m));
  endfunction

  task automatic send(input logic [7:0] c, output int lat);
    int n;
    @(negedge clk);
    chal = c; chal_valid = 1'b1;
    n = 0;
    while (!chal_ready && n < 1000) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    chal_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic ack();
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (chal_ready !== 1'b1) begin failures++; $display("FAIL reset_chal_ready got=%b exp=1", chal_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({core_rst_n, core_vin_valid, resp_valid} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b exp=000", {core_rst_n, core_vin_valid, resp_valid}); end
    checks++; if ({core_C, resp, unstable_mask, unstable_cnt} !== 28'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {core_C, resp, unstable_mask, unstable_cnt}); end
    checks++; if ({resp_valid4, core_rst_n4, chal_ready4} !== 3'b001) begin failures++; $display("FAIL reset_dut4 got=%b exp=001", {resp_valid4, core_rst_n4, chal_ready4}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stable();
    int lat;
    for (int k = 0; k < 8; k++) pat[k] = 8'hA5;
    send(8'hA9, lat);
    checks++; if (lat !== LAT5) begin failures++; $display("FAIL stable_latency got=%0d exp=%0d", lat, LAT5); end
    checks++; if (resp !== 8'hA5) begin failures++; $display("FAIL stable_resp got=%h exp=a5", resp); end
    checks++; if (unstable_mask !== 8'h00 || unstable_cnt !== 4'd0) begin failures++; $display("FAIL stable_mask got=%h/%0d exp=00/0", unstable_mask, unstable_cnt); end
    checks++; if (core_C !== 8'hA9) begin failures++; $display("FAIL stable_core_c got=%h exp=a9", core_C); end
    checks++; if (core_rst_n !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL stable_done_ctrl got=%b%b exp=01", core_rst_n, busy); end
    ack();
    checks++; if (chal_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL stable_ack got=%b%b exp=10", chal_ready, resp_valid); end
    checks++; if (resp !== 8'hA5) begin failures++; $display("FAIL stable_retain got=%h exp=a5", resp); end
  endtask

  task automatic test_flip_bit3();
    int lat;
    for (int k = 0; k < 8; k++) pat[k] = 8'hA5;
    pat[1] = 8'hAD; pat[3] = 8'hAD;
    send(8'h11, lat);
    checks++; if (lat !== LAT5) begin failures++; $display("FAIL bit3_latency got=%0d exp=%0d", lat, LAT5); end
    checks++; if ({resp, unstable_mask, unstable_cnt} !== {8'hA5, 8'h08, 4'd1}) begin failures++; $display("FAIL bit3_result got=%h/%h/%0d exp=a5/08/1", resp, unstable_mask, unstable_cnt); end
    ack();
  endtask

  task automatic test_two_bits();
    int lat;
    pat[0] = 8'h01; pat[1] = 8'h01; pat[2] = 8'h81; pat[3] = 8'h80; pat[4] = 8'h80;
    send(8'h22, lat);
    checks++; if ({resp, unstable_mask, unstable_cnt} !== {8'h81, 8'h81, 4'd2}) begin failures++; $display("FAIL twobit_result got=%h/%h/%0d exp=81/81/2", resp, unstable_mask, unstable_cnt); end
    ack();
  endtask

  task automatic test_random();
    int lat;
    logic [7:0] base, c, er, em;
    logic [3:0] ec;
    for (int it = 0; it < 8; it++) begin
      base = 8'($urandom);
      for (int k = 0; k < 8; k++) pat[k] = base ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      c = 8'($urandom);
      model(0, 5, er, em, ec);
      send(c, lat);
      checks++; if (lat !== LAT5) begin failures++; $display("FAIL rand%0d_latency got=%0d exp=%0d", it, lat, LAT5); end
      checks++; if ({resp, unstable_mask, unstable_cnt} !== {er, em, ec}) begin failures++; $display("FAIL rand%0d_result got=%h/%h/%0d exp=%h/%h/%0d", it, resp, unstable_mask, unstable_cnt, er, em, ec); end
      checks++; if (core_C !== c) begin failures++; $display("FAIL rand%0d_core_c got=%h exp=%h", it, core_C, c); end
      ack();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    for (int k = 0; k < 8; k++) pat[k] = 8'h5A;
    pat[2] = 8'h7A;
    send(8'hC3, lat);
    @(negedge clk);
    chal = 8'h3C; chal_valid = 1'b1; resp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if ({resp_valid, resp, unstable_mask, unstable_cnt} !== {1'b1, 8'h5A, 8'h20, 4'd1}) begin failures++; $display("FAIL bp_hold%0d got=%b/%h/%h/%0d exp=1/5a/20/1", i, resp_valid, resp, unstable_mask, unstable_cnt); end
      checks++; if (chal_ready !== 1'b0 || core_C !== 8'hC3) begin failures++; $display("FAIL bp_block%0d got=%b/%h exp=0/c3", i, chal_ready, core_C); end
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    checks++; if (chal_ready !== 1'b1 || resp_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b%b exp=10", chal_ready, resp_valid); end
    @(posedge clk); #1; chal_valid = 1'b0;
    checks++; if (core_C !== 8'h3C || busy !== 1'b1) begin failures++; $display("FAIL bp_next_accept got=%h/%b exp=3c/1", core_C, busy); end
    lat = 0;
    while (!resp_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== LAT5) begin failures++; $display("FAIL bp_next_latency got=%0d exp=%0d", lat, LAT5); end
    ack();
  endtask

  task automatic test_midreset();
    int lat, n;
    logic [7:0] er, em;
    logic [3:0] ec;
    for (int k = 0; k < 8; k++) pat[k] = 8'hF0;
    @(negedge clk); chal = 8'h77; chal_valid = 1'b1;
    @(posedge clk); #1; chal_valid = 1'b0;
    n = 0;
    while (!(rd_cnt == 8'd2 && core_vin_valid) && n < 1000) begin @(posedge clk); #1; n++; end
    checks++; if (n >= 1000) begin failures++; $display("FAIL midrst_reach got=timeout exp=read3_settle"); end
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if ({chal_ready, busy, core_rst_n, core_vin_valid, resp_valid} !== 5'b10000) begin failures++; $display("FAIL midrst_ctrl got=%b exp=10000", {chal_ready, busy, core_rst_n, core_vin_valid, resp_valid}); end
    checks++; if ({core_C, resp, unstable_mask, unstable_cnt} !== 28'h0) begin failures++; $display("FAIL midrst_data got=%h exp=0", {core_C, resp, unstable_mask, unstable_cnt}); end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 8; k++) pat[k] = 8'h0F ^ ((k == 0 || k == 4) ? 8'h30 : 8'h00);
    model(0, 5, er, em, ec);
    send(8'h78, lat);
    checks++; if (lat !== LAT5) begin failures++; $display("FAIL midrst_latency got=%0d exp=%0d", lat, LAT5); end
    checks++; if ({resp, unstable_mask, unstable_cnt} !== {er, em, ec}) begin failures++; $display("FAIL midrst_result got=%h/%h/%0d exp=%h/%h/%0d", resp, unstable_mask, unstable_cnt, er, em, ec); end
    ack();
  endtask

  task automatic test_back_to_back();
    int acc [$];
    logic [7:0] res [$];
    logic [7:0] msk [$];
    logic [7:0] base, er, em;
    logic [3:0] ec;
    logic prev_rv;
    base = 8'($urandom) & 8'hFD;
    pat4[0] = base | 8'h02; pat4[1] = base | 8'h02; pat4[2] = base; pat4[3] = base;
    for (int k = 4; k < 8; k++) pat4[k] = base;
    model(1, 4, er, em, ec);
    @(negedge clk); chal4 = 8'h5D; chal_valid4 = 1'b1;
    prev_rv = 1'b0;
    for (int cyc = 0; cyc < 400 && acc.size() < 3; cyc++) begin
      if (chal_valid4 && chal_ready4) acc.push_back(cyc);
      if (resp_valid4 && !prev_rv) begin res.push_back(resp4); msk.push_back(unstable_mask4); end
      prev_rv = resp_valid4;
      @(negedge clk);
    end
    chal_valid4 = 1'b0;
    checks++; if (acc.size() !== 3 || res.size() < 2) begin failures++; $display("FAIL b2b_count got=%0d/%0d exp=3/2", acc.size(), res.size()); end
    else begin
      checks++; if (acc[1] - acc[0] !== LAT4 + 2) begin failures++; $display("FAIL b2b_gap1 got=%0d exp=%0d", acc[1] - acc[0], LAT4 + 2); end
      checks++; if (acc[2] - acc[1] !== LAT4 + 2) begin failures++; $display("FAIL b2b_gap2 got=%0d exp=%0d", acc[2] - acc[1], LAT4 + 2); end
      checks++; if (res[0][1] !== 1'b0 || msk[0][1] !== 1'b1) begin failures++; $display("FAIL even_tie_bit1 got=%b/%b exp=0/1", res[0][1], msk[0][1]); end
      checks++; if (res[0] !== er || msk[0] !== em) begin failures++; $display("FAIL even_result0 got=%h/%h exp=%h/%h", res[0], msk[0], er, em); end
      checks++; if (res[1] !== er || msk[1] !== em) begin failures++; $display("FAIL even_result1 got=%h/%h exp=%h/%h", res[1], msk[1], er, em); end
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin pat[k] = '0; pat4[k] = '0; end
    test_reset();
    test_stable();
    test_flip_bit3();
    test_two_bits();
    test_random();
    test_backpressure();
    test_midreset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
